// File: rtl/led_output_driver.sv
// LED pin driver: registers the LED register bus and applies steady/blink/chase/off
// display modes with 4-bit PWM brightness, all timed from an internal prescaler.
module led_output_driver #(
    parameter int PRESCALE    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] bus_leds,
    input  logic [1:0] mode,
    input  logic [3:0] brightness,
    output logic [7:0] leds,
    output logic       step
);

    // state     | meaning
    // ST_STEADY | pattern shown continuously (PWM only)
    // ST_BLINK  | pattern gated by blink_phase, toggled every step
    // ST_CHASE  | single walking bit masked by the pattern
    // ST_OFF    | all LEDs dark, counters keep running
    typedef enum logic [1:0] {
        ST_STEADY = 2'b00,
        ST_BLINK  = 2'b01,
        ST_CHASE  = 2'b10,
        ST_OFF    = 2'b11
    } state_t;

    localparam int PW = $clog2(PRESCALE);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    logic [7:0]    led_q, led_d;
    logic [1:0]    mode_q, mode_d;
    logic [3:0]    bright_q, bright_d;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [3:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    pattern_q, pattern_d;
    logic          blink_phase_q, blink_phase_d;
    logic [7:0]    leds_q, leds_d;
    logic          step_q, step_d;
    state_t        state_q, state_d;

    logic       tick;
    logic       blink_wrap;
    logic       enter_blink;
    logic       enter_chase;
    logic       step_evt;
    logic       pwm_on;
    logic       phase_cur;
    logic [7:0] pattern_cur;

    always_comb begin
        led_d    = bus_leds;
        mode_d   = mode;
        bright_d = brightness;

        tick       = (pre_cnt_q == PW'(PRESCALE - 1));
        pre_cnt_d  = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d  = pwm_cnt_q + 4'd1;
        blink_wrap = tick && (blink_cnt_q == BW'(BLINK_TICKS - 1));

        state_d     = state_t'(mode_q);
        enter_blink = (state_d == ST_BLINK) && (state_q != ST_BLINK);
        enter_chase = (state_d == ST_CHASE) && (state_q != ST_CHASE);

        // A mode entry restarts the step timebase and swallows a coincident step.
        step_evt = blink_wrap && !enter_blink && !enter_chase;

        if (enter_blink || enter_chase) begin
            blink_cnt_d = '0;
        end else if (tick) begin
            blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        end else begin
            blink_cnt_d = blink_cnt_q;
        end

        phase_cur   = enter_blink ? 1'b1 : blink_phase_q;
        pattern_cur = enter_chase ? 8'h01 : pattern_q;

        blink_phase_d = phase_cur;
        if (state_d == ST_BLINK && step_evt) begin
            blink_phase_d = ~phase_cur;
        end

        pattern_d = pattern_cur;
        if (state_d == ST_CHASE && step_evt) begin
            pattern_d = {pattern_cur[6:0], pattern_cur[7]};
        end

        pwm_on = (bright_q == 4'hF) || (pwm_cnt_q < bright_q);

        leds_d = 8'h00;
        case (state_d)
            ST_STEADY: leds_d = led_q & {8{pwm_on}};
            ST_BLINK:  leds_d = led_q & {8{pwm_on & phase_cur}};
            ST_CHASE:  leds_d = pattern_cur & led_q & {8{pwm_on}};
            default:   leds_d = 8'h00;
        endcase

        step_d = step_evt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q         <= 8'h00;
            mode_q        <= 2'b00;
            bright_q      <= 4'h0;
            pre_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            pwm_cnt_q     <= 4'h0;
            pattern_q     <= 8'h01;
            blink_phase_q <= 1'b1;
            leds_q        <= 8'h00;
            step_q        <= 1'b0;
            state_q       <= ST_STEADY;
        end else begin
            led_q         <= led_d;
            mode_q        <= mode_d;
            bright_q      <= bright_d;
            pre_cnt_q     <= pre_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            pattern_q     <= pattern_d;
            blink_phase_q <= blink_phase_d;
            leds_q        <= leds_d;
            step_q        <= step_d;
            state_q       <= state_d;
        end
    end

    assign leds = leds_q;
    assign step = step_q;

endmodule

// File: tb/tb_led_output_driver.sv
// Bench for led_output_driver: closed-form timing model checked every cycle,
// plus directed literal expectations at the key points of each display mode.
module tb_led_output_driver;

    localparam int P  = 4;
    localparam int BT = 3;
    localparam int HN = 4096;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_leds;
    logic [1:0] mode;
    logic [3:0] brightness;
    logic [7:0] leds;
    logic       step;

    int checks = 0;
    int errors = 0;

    led_output_driver #(.PRESCALE(P), .BLINK_TICKS(BT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus_leds   (bus_leds),
        .mode       (mode),
        .brightness (brightness),
        .leds       (leds),
        .step       (step)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Input history per clock edge since reset release; edge 0 is the reset state.
    logic [7:0] h_leds   [0:HN-1];
    logic [1:0] h_mode   [0:HN-1];
    logic [3:0] h_bright [0:HN-1];
    int         e_cnt;
    int         last_r;

    function automatic logic [1:0] mq(input int k);
        return (k <= 0) ? 2'b00 : h_mode[k];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt  <= 0;
            last_r <= 0;
        end else begin
            automatic int ne = e_cnt + 1;
            if (ne < HN) begin
                h_leds[ne]   <= bus_leds;
                h_mode[ne]   <= mode;
                h_bright[ne] <= brightness;
            end
            // Entering blink or chase at this edge restarts the step timebase.
            if ((mq(ne - 1) == 2'b01 || mq(ne - 1) == 2'b10) && mq(ne - 2) != mq(ne - 1))
                last_r <= ne;
            e_cnt <= ne;
        end
    end

    function automatic logic [7:0] exp_leds(input int e);
        int         k;
        int         pwm;
        int         steps;
        logic [7:0] l;
        logic [3:0] b;
        logic [1:0] m;
        logic [7:0] one;
        logic [7:0] pat;
        bit         on;
        k     = e - 1;
        l     = (k > 0) ? h_leds[k] : 8'h00;
        b     = (k > 0) ? h_bright[k] : 4'h0;
        m     = mq(k);
        pwm   = k % 16;
        on    = (b == 4'hF) || (pwm < int'(b));
        steps = (k >= last_r) ? ((k / P - last_r / P) / BT) : 0;
        one   = 8'h01;
        pat   = one << (steps % 8);
        case (m)
            2'b00:   return on ? l : 8'h00;
            2'b01:   return (on && (steps % 2 == 0)) ? l : 8'h00;
            2'b10:   return on ? (pat & l) : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_step(input int e);
        int tk;
        tk = e / P - last_r / P;
        return (e % P == 0) && (tk > 0) && (tk % BT == 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_check();
        if (rst_n && e_cnt >= 1 && e_cnt < HN) begin
            chk("model_leds", {24'h0, leds}, {24'h0, exp_leds(e_cnt)});
            chk("model_step", {31'h0, step}, {31'h0, exp_step(e_cnt)});
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            model_check();
        end
    endtask

    task automatic wait_step(input string nm, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (step) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'h0, ok}, 32'h1);
    endtask

    task automatic wait_leds(input string nm, input logic [7:0] val, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cyc(1);
            if (leds == val) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, {31'h0, ok}, 32'h1);
    endtask

    task automatic drive(input logic [7:0] b, input logic [1:0] m, input logic [3:0] br);
        bus_leds   = b;
        mode       = m;
        brightness = br;
    endtask

    int hi;

    initial begin
        rst_n = 1'b0;
        drive(8'h00, 2'b00, 4'h0);
        repeat (3) @(negedge clk);
        chk("reset_leds", {24'h0, leds}, 32'h0);
        chk("reset_step", {31'h0, step}, 32'h0);
        rst_n = 1'b1;

        // Steady full brightness: two-cycle latency, step every 12 cycles.
        drive(8'hA5, 2'b00, 4'hF);
        cyc(1);
        chk("steady_lat1", {24'h0, leds}, 32'h00);
        cyc(1);
        chk("steady_lat2", {24'h0, leds}, 32'hA5);
        wait_step("step1_seen", 20);
        chk("step1_edge", e_cnt, 32'd12);
        wait_step("step2_seen", 20);
        chk("step2_edge", e_cnt, 32'd24);

        // PWM brightness 4: four lit cycles in every sixteen.
        drive(8'hFF, 2'b00, 4'h4);
        cyc(3);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (leds == 8'hFF) hi++;
        end
        chk("pwm4_duty", hi, 32'd4);
        drive(8'hFF, 2'b00, 4'h0);
        cyc(20);
        chk("pwm0_dark", {24'h0, leds}, 32'h0);

        // Blink: lit on entry, toggles every step, re-entry restarts lit.
        drive(8'h0F, 2'b01, 4'hF);
        cyc(2);
        chk("blink_entry", {24'h0, leds}, 32'h0F);
        cyc(30);
        wait_leds("blink_off_phase", 8'h00, 30);
        mode = 2'b00;
        cyc(1);
        mode = 2'b01;
        cyc(2);
        chk("blink_reentry", {24'h0, leds}, 32'h0F);
        cyc(10);
        bus_leds = 8'h3C;
        cyc(30);

        // Chase over a full pattern, then with a half-populated bus.
        drive(8'hFF, 2'b10, 4'hF);
        cyc(2);
        chk("chase_entry", {24'h0, leds}, 32'h01);
        cyc(13);
        chk("chase_step1", {24'h0, leds}, 32'h02);
        cyc(100);
        bus_leds = 8'h0F;
        cyc(100);

        // Off mid-chase, then return restarts the walk at bit 0.
        bus_leds = 8'hFF;
        wait_leds("chase_at_08", 8'h08, 120);
        mode = 2'b11;
        cyc(2);
        chk("off_dark", {24'h0, leds}, 32'h0);
        cyc(10);
        mode = 2'b10;
        cyc(2);
        chk("chase_restart", {24'h0, leds}, 32'h01);
        cyc(20);

        // Empty bus is dark in every mode.
        for (int m = 0; m < 4; m++) begin
            drive(8'h00, 2'(m), 4'hF);
            cyc(15);
            chk("empty_bus", {24'h0, leds}, 32'h0);
        end

        // Asynchronous reset pulse mid-blink, entirely between clock edges.
        drive(8'hFF, 2'b01, 4'hF);
        cyc(17);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_leds", {24'h0, leds}, 32'h0);
        chk("async_rst_step", {31'h0, step}, 32'h0);
        drive(8'hFF, 2'b00, 4'hF);
        #1 rst_n = 1'b1;
        cyc(2);
        chk("post_rst_leds", {24'h0, leds}, 32'hFF);
        wait_step("post_rst_step", 20);
        chk("post_rst_step_edge", e_cnt, 32'd12);
        cyc(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_output_driver.md
Name: led_output_driver

Overview:
- Downstream stage of the memory-mapped LED register. Consumes its 8-bit LED bus and drives the physical LED pins.
- Applies one of four display modes (steady, blink, chase, off) plus 4-bit global PWM brightness.
- All timing comes from an internal prescaler, so the processor only writes static values.

Parameters:
- PRESCALE, 50000, clk cycles per base tick (1 kHz at 50 MHz); legal range 2 or more.
- BLINK_TICKS, 250, base ticks per blink/chase step; legal range 1 or more.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- bus_leds  input  8  LED enable pattern from the LED register.
- mode  input  2  00 steady, 01 blink, 10 chase, 11 off.
- brightness  input  4  PWM duty: 0 dark, 15 fully on.
- leds  output  8  registered drive to the LED pins.
- step  output  1  one-cycle pulse on every blink/chase step event, for debug.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - leds=0x00, step=0; all counters 0.
  - Input shadow registers (led_q, mode_q, bright_q) 0; so mode_q=00 (steady) and state=STEADY.
  - chase pattern=0x01; blink_phase=1.
- Input stage: bus_leds, mode and brightness are registered into led_q, mode_q and bright_q every cycle.
- Output stage: leds is registered from the shadow registers. An input change reaches leds 2 cycles later, subject to PWM and mode.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1, then wraps to 0.
  - tick is high for 1 cycle when pre_cnt==PRESCALE-1.
- Step counter:
  - On tick, blink_cnt increments.
  - When blink_cnt==BLINK_TICKS-1 and tick, blink_cnt wraps to 0 and a step event fires; step=1 on the following cycle.
  - The step event period is PRESCALE*BLINK_TICKS cycles.
- PWM:
  - pwm_cnt is a free-running 4-bit counter, incrementing every clk and wrapping 15->0.
  - pwm_on = (bright_q==15) | (pwm_cnt < bright_q).
  - brightness 0 gives pwm_on=0 always; brightness 15 gives pwm_on=1 always.
- FSM states STEADY, BLINK, CHASE, OFF; the next state is decoded from mode_q every cycle.
  - Entering BLINK from any other state: blink_phase=1 and blink_cnt=0, taking priority over a coincident step event.
  - Entering CHASE from any other state: pattern=0x01 and blink_cnt=0.
  - Prescaler and pwm_cnt are never cleared by a mode change.
- Next leds value per state:
  - STEADY: led_q & {8{pwm_on}}.
  - BLINK: led_q & {8{pwm_on & blink_phase}}; blink_phase toggles on each step event.
  - CHASE: pattern & led_q & {8{pwm_on}}; on each step event, pattern rotates left by 1 (0x80 -> 0x01).
  - OFF: 0x00. Counters keep running; pattern and phase hold.
- Boundary cases:
  - bus_leds=0x00 gives leds=0x00 in every mode.
  - In CHASE, a pattern bit whose led_q bit is 0 gives a dark step; no bits are skipped.
  - bus_leds changing mid-blink takes effect 2 cycles later without disturbing the phase.
  - Reset asserted mid-operation forces the reset values immediately; on release, counting restarts from 0.

Test Plan (PRESCALE=4, BLINK_TICKS=3, so step period 12 cycles):
- Reset, then mode=00, brightness=15, bus_leds=0xA5 -> leds=0xA5 exactly 2 cycles after the input change; step pulses every 12 cycles.
- mode=00, brightness=4, bus_leds=0xFF -> leds=0xFF for 4 of every 16 cycles and 0x00 for 12; brightness=0 -> leds constantly 0x00.
- mode=01, brightness=15, bus_leds=0x0F -> leds=0x0F immediately on entry, then alternates 0x00/0x0F every 12 cycles; re-entering BLINK mid-off-phase restarts at 0x0F.
- mode=10, brightness=15, bus_leds=0xFF -> leds=0x01,0x02,...,0x80,0x01 with 12 cycles per step; with bus_leds=0x0F, steps 5-8 give 0x00.
- mode=11 during chase at pattern 0x08 -> leds=0x00; return to 10 -> restarts at 0x01.
- rst_n pulsed low asynchronously mid-blink (no clk edge) -> leds=0x00 and step=0 immediately; after release, steady 0xFF input shows 0xFF after 2 cycles and the first step occurs 12 cycles after release.
